// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU between two valid/ready requesters.
// Each accepted request runs IDLE -> ISSUE -> CAPTURE -> RESP before the next can be accepted.
module alu_arbiter #(
    parameter int NUMBITS = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [NUMBITS-1:0] req0_a,
    input  logic [NUMBITS-1:0] req0_b,
    input  logic [2:0]         req0_op,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [NUMBITS-1:0] req1_a,
    input  logic [NUMBITS-1:0] req1_b,
    input  logic [2:0]         req1_op,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [NUMBITS-1:0] rsp0_result,
    output logic               rsp0_zero,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [NUMBITS-1:0] rsp1_result,
    output logic               rsp1_zero,
    output logic [NUMBITS-1:0] alu_a,
    output logic [NUMBITS-1:0] alu_b,
    output logic [2:0]         alu_opcode,
    input  logic [NUMBITS-1:0] alu_result,
    input  logic               alu_zero,
    output logic               busy,
    output logic [15:0]        op_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    state_t             r_state;
    logic [NUMBITS-1:0] r_a, r_b, r_rsp0_result, r_rsp1_result;
    logic [2:0]         r_op;
    logic               r_owner, r_last_grant;
    logic               r_rsp0_valid, r_rsp1_valid, r_rsp0_zero, r_rsp1_zero;
    logic [15:0]        r_count;
    logic               w_idle, w_grant0, w_grant1, w_rsp_hs;

    // On a tie the requester that did not win last time gets the grant.
    assign w_grant1   = req1_valid && (!req0_valid || !r_last_grant);
    assign w_grant0   = req0_valid && !w_grant1;
    assign w_idle     = (r_state == IDLE);
    assign w_rsp_hs   = (r_state == RESP) && (r_owner ? rsp1_ready : rsp0_ready);
    assign req0_ready = w_idle && w_grant0;
    assign req1_ready = w_idle && w_grant1;
    assign busy       = !w_idle;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_opcode = r_op;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_result = r_rsp0_result;
    assign rsp1_result = r_rsp1_result;
    assign rsp0_zero  = r_rsp0_zero;
    assign rsp1_zero  = r_rsp1_zero;
    assign op_count   = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp0_result <= '0;
            r_rsp1_result <= '0;
            r_rsp0_zero   <= 1'b0;
            r_rsp1_zero   <= 1'b0;
            r_count       <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_grant0 || w_grant1) begin
                    r_a          <= w_grant1 ? req1_a : req0_a;
                    r_b          <= w_grant1 ? req1_b : req0_b;
                    r_op         <= w_grant1 ? req1_op : req0_op;
                    r_owner      <= w_grant1;
                    r_last_grant <= w_grant1;
                    r_state      <= ISSUE;
                end
                ISSUE: r_state <= CAPTURE;
                CAPTURE: begin
                    if (r_owner) begin
                        r_rsp1_result <= alu_result;
                        r_rsp1_zero   <= alu_zero;
                        r_rsp1_valid  <= 1'b1;
                    end else begin
                        r_rsp0_result <= alu_result;
                        r_rsp0_zero   <= alu_zero;
                        r_rsp0_valid  <= 1'b1;
                    end
                    r_state <= RESP;
                end
                RESP: if (w_rsp_hs) begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_count      <= r_count + 16'd1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end
endmodule
